// File: rtl/flash_word_packer_pkg.sv
// Shared definitions for the flash word packer: widths, pad byte, FSM states and
// the byte-pair packing helper.
package flash_word_packer_pkg;

  localparam int unsigned FLASH_CNT_W  = 14;
  localparam int unsigned FLASH_WORD_W = 16;
  localparam logic [7:0]  PAD_BYTE     = 8'h00;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StFlush   = 2'd2,
    StFinish  = 2'd3
  } state_e;

  // Places the first-received byte in the low or high half of the word.
  function automatic logic [FLASH_WORD_W-1:0] pack_word(input logic [7:0] first_byte,
                                                        input logic [7:0] second_byte,
                                                        input logic       big_endian);
    pack_word = big_endian ? {first_byte, second_byte} : {second_byte, first_byte};
  endfunction

endpackage

// File: rtl/flash_csum16.sv
// 16-bit running byte checksum: sum of zero-extended bytes, wrapping modulo 2**16.
module flash_csum16
  import flash_word_packer_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    en,
  input  logic [7:0]              data,
  output logic [FLASH_WORD_W-1:0] sum
);

  logic [FLASH_WORD_W-1:0] sum_q;

  // Accumulator: clear wins over a same-cycle byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else if (clear) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= sum_q + {{(FLASH_WORD_W-8){1'b0}}, data};
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/flash_word_packer.sv
// Packs the flash reader's byte stream into 16-bit words written to a 256x16 EBR.
// Optional checksum enabled by defining FLASH_PACKER_CSUM_EN; otherwise csum is 0.
module flash_word_packer
  import flash_word_packer_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [FLASH_CNT_W-1:0]  byte_count,
  input  logic [ADDR_W-1:0]       wr_base,
  input  logic [7:0]              data,
  input  logic                    data_valid,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [FLASH_WORD_W-1:0] ram_wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    stray,
  output logic [FLASH_WORD_W-1:0] csum
);

  state_e                  state_q, state_d;
  logic [FLASH_CNT_W-1:0]  total_q, total_d;
  logic [FLASH_CNT_W-1:0]  cnt_q, cnt_d;
  logic [FLASH_CNT_W-1:0]  cnt_inc;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [ADDR_W-1:0]       word_idx_q, word_idx_d;
  logic [7:0]              half_q, half_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [FLASH_WORD_W-1:0] wdata_q, wdata_d;
  logic                    stray_q, stray_d;
  logic                    accept;
  logic                    start_ok;

  assign cnt_inc  = cnt_q + FLASH_CNT_W'(1);
  assign start_ok = start && (state_q == StIdle);

  // State and datapath registers; write port outputs hold between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      total_q    <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      word_idx_q <= '0;
      half_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      word_idx_q <= word_idx_d;
      half_q     <= half_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      stray_q    <= stray_d;
    end
  end

  // Next-state: byte collection, word assembly and write scheduling.
  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    word_idx_d = word_idx_q;
    half_d     = half_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    stray_d    = stray_q;
    accept     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // A byte arriving with start is dropped without flagging stray.
          total_d    = byte_count;
          base_d     = wr_base;
          cnt_d      = '0;
          word_idx_d = '0;
          stray_d    = 1'b0;
          state_d    = (byte_count == '0) ? StFinish : StCollect;
        end else if (data_valid) begin
          stray_d = 1'b1;
        end
      end
      StCollect: begin
        if (cnt_q == total_q) begin
          // Final even word is on the write port this cycle.
          state_d = StFinish;
        end else if (data_valid) begin
          accept = 1'b1;
          cnt_d  = cnt_inc;
          if (!cnt_q[0]) begin
            half_d = data;
            if (cnt_inc == total_q) begin
              we_d       = 1'b1;
              addr_d     = base_q + word_idx_q;
              wdata_d    = pack_word(data, PAD_BYTE, BIG_ENDIAN);
              word_idx_d = word_idx_q + ADDR_W'(1);
              state_d    = StFlush;
            end
          end else begin
            we_d       = 1'b1;
            addr_d     = base_q + word_idx_q;
            wdata_d    = pack_word(half_q, data, BIG_ENDIAN);
            word_idx_d = word_idx_q + ADDR_W'(1);
          end
        end
      end
      StFlush: begin
        state_d = StFinish;
      end
      StFinish: begin
        state_d = StIdle;
        if (data_valid) begin
          stray_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFinish);
  assign stray     = stray_q;

`ifdef FLASH_PACKER_CSUM_EN
  flash_csum16 u_csum (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok),
    .en    (accept),
    .data  (data),
    .sum   (csum)
  );
`else
  logic unused_csum;
  assign unused_csum = ^{start_ok, accept};
  assign csum        = '0;
`endif

endmodule

// File: tb/tb_flash_word_packer.sv
// Scoreboard bench for flash_word_packer: little- and big-endian instances share
// stimulus; expected writes and done cycles are queued and checked by a monitor.
module tb_flash_word_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] byte_count;
  logic [7:0]  wr_base;
  logic [7:0]  data;
  logic        data_valid;

  logic        ram_we_le, ram_we_be;
  logic [7:0]  ram_addr_le, ram_addr_be;
  logic [15:0] ram_wdata_le, ram_wdata_be;
  logic        busy_le, busy_be;
  logic        done_le, done_be;
  logic        stray_le, stray_be;
  logic [15:0] csum_le, csum_be;

  flash_word_packer #(.ADDR_W(8), .BIG_ENDIAN(1'b0)) u_dut_le (
    .clk(clk), .reset(reset), .start(start), .byte_count(byte_count), .wr_base(wr_base),
    .data(data), .data_valid(data_valid), .ram_we(ram_we_le), .ram_addr(ram_addr_le),
    .ram_wdata(ram_wdata_le), .busy(busy_le), .done(done_le), .stray(stray_le),
    .csum(csum_le)
  );

  flash_word_packer #(.ADDR_W(8), .BIG_ENDIAN(1'b1)) u_dut_be (
    .clk(clk), .reset(reset), .start(start), .byte_count(byte_count), .wr_base(wr_base),
    .data(data), .data_valid(data_valid), .ram_we(ram_we_be), .ram_addr(ram_addr_be),
    .ram_wdata(ram_wdata_be), .busy(busy_be), .done(done_be), .stray(stray_be),
    .csum(csum_be)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] wdata;
  } wr_t;

  wr_t exp_le[$];
  wr_t exp_be[$];
  int  exp_done[$];
  wr_t w_le, w_be;
  int  d_exp;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write and done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (ram_we_le) begin
      if (exp_le.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL le_write_unexpected actual=%0h:%0h required=none",
                 ram_addr_le, ram_wdata_le);
      end else begin
        w_le = exp_le.pop_front();
        check("le_addr", ram_addr_le, w_le.addr);
        check("le_wdata", ram_wdata_le, w_le.wdata);
      end
    end
    if (ram_we_be) begin
      if (exp_be.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL be_write_unexpected actual=%0h:%0h required=none",
                 ram_addr_be, ram_wdata_be);
      end else begin
        w_be = exp_be.pop_front();
        check("be_addr", ram_addr_be, w_be.addr);
        check("be_wdata", ram_wdata_be, w_be.wdata);
      end
    end
    if (done_le) begin
      if (exp_done.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected actual=cycle %0d required=none", cyc);
      end else begin
        d_exp = exp_done.pop_front();
        check("done_cycle", cyc, d_exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_wr(input logic [7:0] addr, input logic [15:0] le, input logic [15:0] be);
    exp_le.push_back({addr, le});
    exp_be.push_back({addr, be});
  endtask

  task automatic do_start(input logic [13:0] count, input logic [7:0] base);
    byte_count = count;
    wr_base    = base;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    data       = b;
    data_valid = 1'b1;
    tick(1);
    data_valid = 1'b0;
    tick(2);
  endtask

  logic [15:0] exp_csum;

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_count = '0;
    wr_base    = '0;
    data       = '0;
    data_valid = 1'b0;
    tick(3);
    check("rst_ram_we", ram_we_le, 1'b0);
    check("rst_ram_addr", ram_addr_le, 8'h00);
    check("rst_ram_wdata", ram_wdata_le, 16'h0000);
    check("rst_busy", busy_le, 1'b0);
    check("rst_done", done_le, 1'b0);
    check("rst_stray", stray_le, 1'b0);
    check("rst_csum", csum_le, 16'h0000);
    reset = 1'b0;
    tick(2);

    // T1: four bytes, even count; a start while busy must be ignored.
    do_start(14'd4, 8'h10);
    check("t1_busy", busy_le, 1'b1);
    tick(3);
    send(8'h11);
    push_wr(8'h10, 16'h2211, 16'h1122);
    send(8'h22);
    do_start(14'd7, 8'h55);
    check("t1_busy_hold", busy_le, 1'b1);
    send(8'h33);
    push_wr(8'h11, 16'h4433, 16'h3344);
    exp_done.push_back(cyc + 2);
    send(8'h44);
`ifdef FLASH_PACKER_CSUM_EN
    exp_csum = 16'h00AA;
`else
    exp_csum = 16'h0000;
`endif
    check("t1_csum", csum_le, exp_csum);
    check("t1_idle", busy_le, 1'b0);
    tick(3);

    // T2: odd count, last byte padded.
    do_start(14'd3, 8'h20);
    tick(3);
    push_wr(8'h20, 16'hCDAB, 16'hABCD);
    send(8'hAB);
    send(8'hCD);
    push_wr(8'h21, 16'h00EF, 16'hEF00);
    exp_done.push_back(cyc + 2);
    send(8'hEF);
`ifdef FLASH_PACKER_CSUM_EN
    exp_csum = 16'h0267;
`else
    exp_csum = 16'h0000;
`endif
    check("t2_csum", csum_le, exp_csum);
    tick(3);

    // T3: two bytes at base 0; big-endian instance gives 1234.
    do_start(14'd2, 8'h00);
    tick(3);
    send(8'h12);
    push_wr(8'h00, 16'h3412, 16'h1234);
    exp_done.push_back(cyc + 2);
    send(8'h34);
    tick(3);

    // T4: zero-length transfer.
    exp_done.push_back(cyc + 1);
    do_start(14'd0, 8'h30);
    check("t4_busy_on", busy_le, 1'b1);
    tick(1);
    check("t4_busy_off", busy_le, 1'b0);
    tick(3);

    // T5: address wrap from FF to 00.
    do_start(14'd4, 8'hFF);
    tick(3);
    send(8'h01);
    push_wr(8'hFF, 16'h0201, 16'h0102);
    send(8'h02);
    send(8'h03);
    push_wr(8'h00, 16'h0403, 16'h0304);
    exp_done.push_back(cyc + 2);
    send(8'h04);
`ifdef FLASH_PACKER_CSUM_EN
    exp_csum = 16'h000A;
`else
    exp_csum = 16'h0000;
`endif
    check("t5_csum", csum_le, exp_csum);
    tick(3);

    // T6: stray byte in idle, cleared by start, then reset mid-transfer.
    check("t6_stray_pre", stray_le, 1'b0);
    data       = 8'h77;
    data_valid = 1'b1;
    tick(1);
    data_valid = 1'b0;
    check("t6_stray_set", stray_le, 1'b1);
    tick(2);
    check("t6_stray_hold", stray_le, 1'b1);
    do_start(14'd4, 8'h40);
    check("t6_stray_clr", stray_le, 1'b0);
    tick(3);
    send(8'h99);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t6_rst_we", ram_we_le, 1'b0);
    check("t6_rst_busy", busy_le, 1'b0);
    check("t6_rst_done", done_le, 1'b0);
    check("t6_rst_csum", csum_le, 16'h0000);
    tick(6);

    check("le_pending", exp_le.size(), 0);
    check("be_pending", exp_be.size(), 0);
    check("done_pending", exp_done.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
